intt_sequencer: RTL
===================

# intt_sequencer

Host-facing controller that sequences one INTTN core per transform. It buffers a full polynomial arriving on a stallable ready/valid stream, then replays it to the core as the contiguous `load_data` + `din` burst the core requires, and issues `start_intt`. It then captures the wide `bramOut` burst that follows `done` and serialises the result back to the host on a second ready/valid stream. It sits between the system interconnect and INTTN and ties the core's NTT-only controls (`load_w`, `start`) low.

## Interface
- `DATA_SIZE_ARB`, default 32: coefficient width.
- `RING_SIZE`, default 1024: coefficients per polynomial; must be a power of two.
- `PE_NUMBER`, default 8: core PE count; core output word is `2*PE_NUMBER` coefficients.
- `PE_DEPTH`, default 3: log2(`PE_NUMBER`).
- `GAP_CYCLES`, default 5: idle cycles between end of load burst and `start_intt`.
- `TIMEOUT`, default 65535: maximum cycles spent waiting for `done`.
- `clk`, in, 1: single clock; all logic rising-edge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `in_valid`, in, 1: host input coefficient valid.
- `in_ready`, out, 1: sequencer accepts input.
- `in_data`, in, `DATA_SIZE_ARB`: input coefficient, natural index order.
- `out_valid`, out, 1: result coefficient valid.
- `out_ready`, in, 1: host accepts result.
- `out_data`, out, `DATA_SIZE_ARB`: result coefficient, natural index order.
- `busy`, out, 1: high in every state except FILL.
- `timeout_err`, out, 1: sticky; set on `done` timeout; cleared by the first input handshake of the next job.
- `load_w`, out, 1: constant 0.
- `load_data`, out, 1: one-cycle pulse preceding the din burst.
- `start`, out, 1: constant 0.
- `start_intt`, out, 1: one-cycle start pulse.
- `din`, out, `DATA_SIZE_ARB`: coefficient to core.
- `done`, in, 1: core completion flag.
- `bramOut`, in, `DATA_SIZE_ARB*2*PE_NUMBER`: core wide output; lane n at bits `[DATA_SIZE_ARB*n +: DATA_SIZE_ARB]`.

## Operation
- One internal buffer of `RING_SIZE` words is shared by input and output phases. The phases never overlap.
- `BEATS = RING_SIZE >> (PE_DEPTH+1)`.
- FILL: `in_ready`=1. Each handshake writes `mem[wcnt]` and increments `wcnt`. The handshake at `wcnt=RING_SIZE-1` moves to LDP.
- LDP (1 cycle): `load_data`=1; `rcnt`=0.
- LOAD (`RING_SIZE` cycles): `din`=`mem[k]` in the k-th cycle after the LDP cycle (k=0..RING_SIZE-1). No gaps. `din` returns to 0 afterwards.
- GAP (`GAP_CYCLES` cycles): all core controls low.
- START (1 cycle): `start_intt`=1.
- WAIT: `tcnt` increments each cycle.
  - `done` sampled high: go to CAPT.
  - `tcnt` reaches `TIMEOUT` first: set `timeout_err`, clear `wcnt`, return to FILL. The core is left as is, with no output.
- CAPT (`BEATS` cycles): starts the cycle after `done` is sampled high. On beat m (m=0..BEATS-1), lane n of `bramOut` is written to `mem[2*PE_NUMBER*m+n]`.
- DRAIN: `out_valid`=1, `out_data`=`mem[ocnt]`.
  - `out_data` is held stable while `out_ready`=0.
  - `ocnt` increments on each handshake. The handshake at `ocnt=RING_SIZE-1` returns to FILL.
- `in_valid` is ignored outside FILL. Further `done` assertions outside WAIT are ignored.

## Timing
- Reset values:
  - all outputs 0, including `in_ready`, `out_valid`, `busy` and `timeout_err`;
  - state FILL; all counters 0.
  - `in_ready` rises on the first clock edge after `reset` deasserts.
- All outputs are registered. `out_data` is valid in the same cycle as `out_valid`.
- Reset mid-operation (any state) aborts immediately:
  - `load_data`, `start_intt`, `din` and `out_valid` drop asynchronously;
  - buffer contents are don't-care;
  - the next job starts at index 0.
- Input throughput: 1 word/cycle with `in_valid` held high.
- Minimum latency from last input handshake to first `out_valid`: 1 + `RING_SIZE` + `GAP_CYCLES` + 1 + core latency + 1 + `BEATS` cycles.
- Output throughput: 1 word/cycle with `out_ready` held high.
- Back-to-back jobs: `in_ready` is 1 in the cycle after the final output handshake.

## Test plan
Bench parameters: `RING_SIZE`=16, `PE_NUMBER`=2, `PE_DEPTH`=1, behavioural core model.

1. Reset: hold `reset` for 3 cycles mid-LOAD -> `load_data`, `din`, `busy`, `in_ready` are 0 during reset. `in_ready`=1 one cycle after release. A fresh 16-word job then completes correctly.
2. Basic job: stream inputs 0..15 with `in_valid` continuously high -> `load_data` pulses once; `din`=0..15 on the next 16 cycles; exactly 5 idle cycles; one `start_intt` pulse.
3. Capture ordering: the model raises `done`, then presents `bramOut` beats whose lane n of beat m equals 100+4m+n -> `out_data` sequence is 100..115 in order.
4. Host backpressure: toggle `in_valid` randomly during FILL and hold `out_ready`=0 for 7 cycles mid-DRAIN -> the `din` burst is still gap-free; `out_data` is stable while stalled; no words are lost or duplicated.
5. Timeout: use `TIMEOUT`=50 with the model never asserting `done` -> `timeout_err`=1 at WAIT cycle 50; `in_ready`=1 the next cycle. `timeout_err` clears on the first input handshake of the next job.
6. Back-to-back: two jobs with `out_ready`=1 -> `in_ready` rises the cycle after the 16th output. The second job's results are correct and `load_w`=`start`=0 throughout.

Source files
------------

// File: rtl/intt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : intt_sequencer
// Purpose  : Buffers one polynomial from the host and replays it to an INTTN
//            core as a load_data + din burst. It then issues start_intt,
//            captures the wide bramOut burst that follows done, and streams
//            the result back to the host in natural index order.
// Revision : 1.0 - initial release
// ============================================================================
module intt_sequencer #(
  parameter int DATA_SIZE_ARB = 32,
  parameter int RING_SIZE     = 1024,
  parameter int PE_NUMBER     = 8,
  parameter int PE_DEPTH      = 3,
  parameter int GAP_CYCLES    = 5,
  parameter int TIMEOUT       = 65535
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_SIZE_ARB-1:0]             in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_SIZE_ARB-1:0]             out_data,
  output logic                                 busy,
  output logic                                 timeout_err,
  output logic                                 load_w,
  output logic                                 load_data,
  output logic                                 start,
  output logic                                 start_intt,
  output logic [DATA_SIZE_ARB-1:0]             din,
  input  logic                                 done,
  input  logic [DATA_SIZE_ARB*2*PE_NUMBER-1:0] bramOut
);

  localparam int c_lanes = 2 * PE_NUMBER;
  localparam int c_beats = RING_SIZE >> (PE_DEPTH + 1);
  localparam int c_aw    = $clog2(RING_SIZE);
  localparam int c_rw    = c_aw + 1;
  localparam int c_bw    = (c_beats > 1) ? $clog2(c_beats) : 1;
  localparam int c_gw    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int c_tw    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FILL  = 3'd0,
    S_LDP   = 3'd1,
    S_LOAD  = 3'd2,
    S_GAP   = 3'd3,
    S_START = 3'd4,
    S_WAIT  = 3'd5,
    S_CAPT  = 3'd6,
    S_DRAIN = 3'd7
  } state_t;

  state_t                   r_state;
  logic [c_aw-1:0]          r_wcnt;
  logic [c_rw-1:0]          r_rcnt;
  logic [c_gw-1:0]          r_gcnt;
  logic [c_tw-1:0]          r_tcnt;
  logic [c_bw-1:0]          r_bcnt;
  logic [c_aw-1:0]          r_ocnt;
  logic [DATA_SIZE_ARB-1:0] r_mem [RING_SIZE];

  logic                     w_in_fire;
  logic [c_aw-1:0]          w_capt_base;
  logic [DATA_SIZE_ARB-1:0] w_first_word;

  // The core's NTT-only controls are never used by this sequencer.
  assign load_w = 1'b0;
  assign start  = 1'b0;

  assign w_in_fire   = (r_state == S_FILL) && in_valid && in_ready;
  assign w_capt_base = c_aw'({r_bcnt, {(PE_DEPTH + 1){1'b0}}});

  // Word 0 lands in the buffer on beat 0; with a single beat that write
  // coincides with loading the first output word, so bypass it.
  assign w_first_word = (r_bcnt == '0) ? bramOut[DATA_SIZE_ARB-1:0] : r_mem[0];

  // Shared buffer: host words are written in FILL, core lanes in CAPT.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_mem[r_wcnt] <= in_data;
    end else if (r_state == S_CAPT) begin
      for (int n = 0; n < c_lanes; n++) begin
        r_mem[w_capt_base + c_aw'(n)] <= bramOut[DATA_SIZE_ARB*n +: DATA_SIZE_ARB];
      end
    end
  end

  // Job sequencer: state, counters and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_FILL;
      r_wcnt      <= '0;
      r_rcnt      <= '0;
      r_gcnt      <= '0;
      r_tcnt      <= '0;
      r_bcnt      <= '0;
      r_ocnt      <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      load_data   <= 1'b0;
      start_intt  <= 1'b0;
      din         <= '0;
    end else begin
      load_data  <= 1'b0;
      start_intt <= 1'b0;
      case (r_state)
        S_FILL: begin
          busy     <= 1'b0;
          in_ready <= 1'b1;
          if (w_in_fire) begin
            timeout_err <= 1'b0;
            r_wcnt      <= r_wcnt + c_aw'(1);
            if (r_wcnt == c_aw'(RING_SIZE - 1)) begin
              r_state   <= S_LDP;
              in_ready  <= 1'b0;
              busy      <= 1'b1;
              load_data <= 1'b1;
              r_rcnt    <= '0;
            end
          end
        end

        S_LDP: begin
          din     <= r_mem[0];
          r_rcnt  <= c_rw'(1);
          r_state <= S_LOAD;
        end

        S_LOAD: begin
          if (r_rcnt == c_rw'(RING_SIZE)) begin
            din     <= '0;
            r_gcnt  <= '0;
            r_state <= S_GAP;
          end else begin
            din    <= r_mem[r_rcnt[c_aw-1:0]];
            r_rcnt <= r_rcnt + c_rw'(1);
          end
        end

        S_GAP: begin
          if (r_gcnt == c_gw'(GAP_CYCLES - 1)) begin
            start_intt <= 1'b1;
            r_state    <= S_START;
          end else begin
            r_gcnt <= r_gcnt + c_gw'(1);
          end
        end

        S_START: begin
          r_tcnt  <= '0;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          // Timeout takes priority: once flagged, a late done is not honoured.
          if (r_tcnt == c_tw'(TIMEOUT)) begin
            r_wcnt   <= '0;
            busy     <= 1'b0;
            in_ready <= 1'b1;
            r_state  <= S_FILL;
          end else if (done) begin
            r_bcnt  <= '0;
            r_state <= S_CAPT;
          end else begin
            r_tcnt <= r_tcnt + c_tw'(1);
            if (r_tcnt + c_tw'(1) == c_tw'(TIMEOUT)) begin
              timeout_err <= 1'b1;
            end
          end
        end

        S_CAPT: begin
          if (r_bcnt == c_bw'(c_beats - 1)) begin
            out_valid <= 1'b1;
            out_data  <= w_first_word;
            r_ocnt    <= '0;
            r_state   <= S_DRAIN;
          end else begin
            r_bcnt <= r_bcnt + c_bw'(1);
          end
        end

        S_DRAIN: begin
          if (out_ready) begin
            if (r_ocnt == c_aw'(RING_SIZE - 1)) begin
              out_valid <= 1'b0;
              out_data  <= '0;
              r_ocnt    <= '0;
              r_wcnt    <= '0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              r_state   <= S_FILL;
            end else begin
              out_data <= r_mem[r_ocnt + c_aw'(1)];
              r_ocnt   <= r_ocnt + c_aw'(1);
            end
          end
        end

        default: begin
          r_state <= S_FILL;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
